// File: rtl/spi_mmio_bridge_if.sv
// CPU bus and spi_controller handshake signals of the bridge.
// slave = bridge side; master = CPU bus plus controller side.
interface spi_mmio_bridge_if;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        irq;
  logic        spi_trigger;
  logic [7:0]  spi_command;
  logic [7:0]  spi_response;
  logic        spi_busy;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re, spi_response, spi_busy,
    input  bus_rdata, irq, spi_trigger, spi_command
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re, spi_response, spi_busy,
    output bus_rdata, irq, spi_trigger, spi_command
  );
endinterface

// File: rtl/spi_mmio_bridge.sv
// MMIO front end for spi_controller: TX FIFO feeds one launch per byte, responses land in an RX FIFO.
// bus_rdata is valid one cycle after bus_re; pushes into a full FIFO are dropped and flagged, never stalled.
module spi_mmio_bridge #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  spi_mmio_bridge_if.slave bus_if
);
  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int RXAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, XFER, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      arm_cnt_q, arm_cnt_d;
  logic [7:0]      cmd_q, cmd_d;
  logic            trig_q, trig_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic            tx_ovf_q, tx_ovf_d;
  logic            rx_ovf_q, rx_ovf_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [7:0]      tx_mem_q [TX_DEPTH];
  logic [TXAW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TXAW:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]      rx_mem_q [RX_DEPTH];
  logic [RXAW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RXAW:0]   rx_cnt_q, rx_cnt_d;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, tx_push_ok;
  logic rx_push, rx_pop, rx_push_ok;
  logic ctrl_wr, arm_timeout;
  logic unused_bus;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == (TXAW+1)'(TX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == (RXAW+1)'(RX_DEPTH));

  assign tx_push    = bus_if.bus_we && (bus_if.bus_addr[3:2] == 2'd0);
  assign ctrl_wr    = bus_if.bus_we && (bus_if.bus_addr[3:2] == 2'd2);
  assign rx_pop     = bus_if.bus_re && !bus_if.bus_we && (bus_if.bus_addr[3:2] == 2'd0) && !rx_empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign tx_push_ok = tx_push && (!tx_full || tx_pop);
  assign rx_push_ok = rx_push && (!rx_full || rx_pop);

  assign unused_bus = ^{bus_if.bus_wdata[31:8], bus_if.bus_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    cmd_d       = cmd_q;
    trig_d      = 1'b0;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    arm_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_q[0] && !tx_empty && !bus_if.spi_busy) begin
          tx_pop    = 1'b1;
          cmd_d     = tx_mem_q[tx_rd_q];
          trig_d    = 1'b1;
          arm_cnt_d = '0;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (bus_if.spi_busy) begin
          state_d = XFER;
        end else if (arm_cnt_q == 2'd3) begin
          arm_timeout = 1'b1;
          state_d     = IDLE;
        end else begin
          arm_cnt_d = arm_cnt_q + 2'd1;
        end
      end
      XFER: begin
        if (!bus_if.spi_busy) state_d = DONE;
      end
      default: begin
        rx_push = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push_ok) tx_wr_d = tx_wr_q + TXAW'(1);
    if (tx_pop)     tx_rd_d = tx_rd_q + TXAW'(1);
    if (tx_push_ok && !tx_pop)      tx_cnt_d = tx_cnt_q + (TXAW+1)'(1);
    else if (!tx_push_ok && tx_pop) tx_cnt_d = tx_cnt_q - (TXAW+1)'(1);

    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push_ok) rx_wr_d = rx_wr_q + RXAW'(1);
    if (rx_pop)     rx_rd_d = rx_rd_q + RXAW'(1);
    if (rx_push_ok && !rx_pop)      rx_cnt_d = rx_cnt_q + (RXAW+1)'(1);
    else if (!rx_push_ok && rx_pop) rx_cnt_d = rx_cnt_q - (RXAW+1)'(1);
  end

  // Overflow set wins over a same-cycle clear so a fresh event is never lost.
  always_comb begin
    ctrl_d   = ctrl_q;
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    if (ctrl_wr) begin
      ctrl_d = bus_if.bus_wdata[1:0];
      if (bus_if.bus_wdata[4]) tx_ovf_d = 1'b0;
      if (bus_if.bus_wdata[5]) rx_ovf_d = 1'b0;
    end
    if ((tx_push && !tx_push_ok) || arm_timeout) tx_ovf_d = 1'b1;
    if (rx_push && !rx_push_ok) rx_ovf_d = 1'b1;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (bus_if.bus_re) begin
      rdata_d = '0;
      if (!bus_if.bus_we) begin
        case (bus_if.bus_addr[3:2])
          2'd0:    if (!rx_empty) rdata_d = {24'b0, rx_mem_q[rx_rd_q]};
          2'd1:    rdata_d = {25'b0, rx_ovf_q, tx_ovf_q, (state_q != IDLE),
                              rx_full, rx_empty, tx_full, tx_empty};
          2'd2:    rdata_d = {30'b0, ctrl_q};
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem_q[tx_wr_q] <= bus_if.bus_wdata[7:0];
    if (rx_push_ok) rx_mem_q[rx_wr_q] <= bus_if.spi_response;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      arm_cnt_q <= '0;
      cmd_q     <= '0;
      trig_q    <= 1'b0;
      ctrl_q    <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      rdata_q   <= '0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      cmd_q     <= cmd_d;
      trig_q    <= trig_d;
      ctrl_q    <= ctrl_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
      rdata_q   <= rdata_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  assign bus_if.bus_rdata   = rdata_q;
  assign bus_if.irq         = ctrl_q[1] && !rx_empty;
  assign bus_if.spi_trigger = trig_q;
  assign bus_if.spi_command = cmd_q;
endmodule

// File: tb/tb_spi_mmio_bridge.sv
// Bench for spi_mmio_bridge: behavioural controller (8-cycle busy, response = command ^ key)
// plus a queue-level model of the register map and FIFOs.
module tb_spi_mmio_bridge;
  localparam int TX_DEPTH = 4;
  localparam int RX_DEPTH = 4;
  localparam logic [3:0] A_DATA   = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_CTRL   = 4'h8;
  localparam logic [3:0] A_RSVD   = 4'hC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  spi_mmio_bridge_if bus_if ();

  spi_mmio_bridge #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  // Controller model: not reset by rst, it always finishes its transfer.
  int         busy_left = 0;
  logic [7:0] ctl_resp = 8'h00;
  logic [7:0] resp_key = 8'h99;
  bit         ctl_mute = 1'b0;
  int         cyc = 0;
  int         trig_count = 0;
  int         trig_busy_count = 0;
  int         trig_cyc [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end else if (bus_if.spi_trigger && !ctl_mute) begin
      busy_left <= 8;
      ctl_resp  <= bus_if.spi_command ^ resp_key;
    end
    if (bus_if.spi_trigger) begin
      trig_count <= trig_count + 1;
      trig_cyc.push_back(cyc);
      if (bus_if.spi_busy) trig_busy_count <= trig_busy_count + 1;
    end
  end

  assign bus_if.spi_busy     = (busy_left != 0);
  assign bus_if.spi_response = ctl_resp;

  // Reference model
  logic [7:0] tx_m [$];
  logic [7:0] rx_m [$];
  bit         tx_ovf_m, rx_ovf_m;
  logic [1:0] ctrl_m;

  function automatic void model_reset();
    tx_m.delete();
    rx_m.delete();
    tx_ovf_m = 1'b0;
    rx_ovf_m = 1'b0;
    ctrl_m   = 2'b00;
  endfunction

  function automatic void model_write(input logic [7:0] b);
    if (tx_m.size() < TX_DEPTH) tx_m.push_back(b);
    else tx_ovf_m = 1'b1;
  endfunction

  function automatic void model_drain();
    logic [7:0] b;
    while (ctrl_m[0] && tx_m.size() > 0) begin
      b = tx_m.pop_front();
      if (rx_m.size() < RX_DEPTH) rx_m.push_back(b ^ resp_key);
      else rx_ovf_m = 1'b1;
    end
  endfunction

  function automatic logic [31:0] model_read();
    if (rx_m.size() == 0) return 32'h0;
    return {24'h0, rx_m.pop_front()};
  endfunction

  function automatic logic [31:0] exp_status(input bit busy);
    return {25'h0, rx_ovf_m, tx_ovf_m, busy, (rx_m.size() == RX_DEPTH), (rx_m.size() == 0),
            (tx_m.size() == TX_DEPTH), (tx_m.size() == 0)};
  endfunction

  // Bus helpers: entered and left on a falling edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    bus_if.bus_we    = 1'b1;
    @(negedge clk);
    bus_if.bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_if.bus_addr = a;
    bus_if.bus_re   = 1'b1;
    @(negedge clk);
    bus_if.bus_re   = 1'b0;
    d = bus_if.bus_rdata;
  endtask

  task automatic wait_triggers(input int n);
    int budget;
    budget = 400;
    while (trig_count < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_if.spi_trigger, bus_if.spi_command, bus_if.irq, bus_if.bus_rdata} !== 42'h0)
      begin errors++; $display("FAIL reset_outputs: trig=%b cmd=%h irq=%b rdata=%h, required all 0",
        bus_if.spi_trigger, bus_if.spi_command, bus_if.irq, bus_if.bus_rdata); end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== exp_status(1'b0)) begin errors++; $display("FAIL reset_status: got %h, required %h", d, exp_status(1'b0)); end
    bus_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h, required 0", d); end
    bus_read(A_RSVD, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h, required 0", d); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    int base, bad;
    resp_key = 8'h99;
    bus_write(A_CTRL, 32'h1);
    ctrl_m = 2'b01;
    base = trig_count;
    bus_write(A_DATA, 32'hA5);
    model_write(8'hA5);
    model_drain();
    wait_triggers(base + 1);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_if.spi_busy && bus_if.spi_command !== 8'hA5) bad++;
    end
    checks++;
    if (trig_count !== base + 1) begin errors++; $display("FAIL single_pulses: got %0d, required 1", trig_count - base); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL single_cmd_hold: %0d busy cycles with command != a5", bad); end
    checks++;
    if (bus_if.spi_command !== 8'hA5) begin errors++; $display("FAIL single_cmd_after: got %h, required a5", bus_if.spi_command); end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== exp_status(1'b0)) begin errors++; $display("FAIL single_status: got %h, required %h", d, exp_status(1'b0)); end
    bus_read(A_DATA, d);
    void'(model_read());
    checks++;
    if (d !== 32'h3C) begin errors++; $display("FAIL single_rx: got %h, required 0000003c", d); end
  endtask

  task automatic test_ordered();
    logic [31:0] d, e;
    logic [7:0]  b;
    int base, sz, worst;
    resp_key = 8'($urandom_range(0, 255));
    bus_write(A_CTRL, 32'h0);
    ctrl_m = 2'b00;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      bus_write(A_DATA, {24'h0, b});
      model_write(b);
    end
    base = trig_count;
    bus_write(A_CTRL, 32'h1);
    ctrl_m = 2'b01;
    model_drain();
    wait_triggers(base + 4);
    repeat (14) @(negedge clk);
    checks++;
    if (trig_count !== base + 4) begin errors++; $display("FAIL ordered_count: got %0d, required 4", trig_count - base); end
    sz = trig_cyc.size();
    worst = 999;
    if (sz >= 4) begin
      worst = 0;
      for (int i = sz - 3; i < sz; i++)
        if (trig_cyc[i] - trig_cyc[i-1] > worst) worst = trig_cyc[i] - trig_cyc[i-1];
    end
    checks++;
    if (worst > 12 || worst < 1) begin errors++; $display("FAIL ordered_spacing: worst gap %0d, required 1..12", worst); end
    for (int i = 0; i < 5; i++) begin
      bus_read(A_DATA, d);
      e = model_read();
      checks++;
      if (d !== e) begin errors++; $display("FAIL ordered_rx%0d: got %h, required %h", i, d, e); end
    end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d, e;
    logic [7:0]  b;
    int base;
    bus_write(A_CTRL, 32'h0);
    ctrl_m = 2'b00;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      bus_write(A_DATA, {24'h0, b});
      model_write(b);
    end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== exp_status(1'b0)) begin errors++; $display("FAIL txovf_status: got %h, required %h", d, exp_status(1'b0)); end
    bus_write(A_CTRL, 32'h10);
    tx_ovf_m = 1'b0;
    bus_read(A_STATUS, d);
    checks++;
    if (d !== exp_status(1'b0)) begin errors++; $display("FAIL txovf_clear: got %h, required %h", d, exp_status(1'b0)); end
    base = trig_count;
    bus_write(A_CTRL, 32'h1);
    ctrl_m = 2'b01;
    model_drain();
    wait_triggers(base + 4);
    repeat (14) @(negedge clk);
    checks++;
    if (trig_count !== base + 4) begin errors++; $display("FAIL txovf_count: got %0d, required 4", trig_count - base); end
    for (int i = 0; i < 4; i++) begin
      bus_read(A_DATA, d);
      e = model_read();
      checks++;
      if (d !== e) begin errors++; $display("FAIL txovf_rx%0d: got %h, required %h", i, d, e); end
    end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] d, e;
    logic [7:0]  b;
    int base;
    bus_write(A_CTRL, 32'h3);
    ctrl_m = 2'b11;
    base = trig_count;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      bus_write(A_DATA, {24'h0, b});
      model_write(b);
      model_drain();
    end
    wait_triggers(base + 5);
    repeat (14) @(negedge clk);
    checks++;
    if (trig_count !== base + 5) begin errors++; $display("FAIL rxovf_count: got %0d, required 5", trig_count - base); end
    checks++;
    if (bus_if.irq !== (ctrl_m[1] && rx_m.size() != 0)) begin errors++; $display("FAIL rxovf_irq: got %b, required 1", bus_if.irq); end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== exp_status(1'b0)) begin errors++; $display("FAIL rxovf_status: got %h, required %h", d, exp_status(1'b0)); end
    for (int i = 0; i < 4; i++) begin
      bus_read(A_DATA, d);
      e = model_read();
      checks++;
      if (d !== e) begin errors++; $display("FAIL rxovf_rx%0d: got %h, required %h", i, d, e); end
    end
    checks++;
    if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL rxovf_irq_drained: got %b, required 0", bus_if.irq); end
    bus_write(A_CTRL, 32'h23);
    rx_ovf_m = 1'b0;
    bus_read(A_STATUS, d);
    checks++;
    if (d !== exp_status(1'b0)) begin errors++; $display("FAIL rxovf_clear: got %h, required %h", d, exp_status(1'b0)); end
  endtask

  task automatic test_arm_timeout();
    logic [31:0] d;
    int base;
    ctl_mute = 1'b1;
    base = trig_count;
    bus_write(A_DATA, {24'h0, 8'($urandom)});
    tx_ovf_m = 1'b1;
    wait_triggers(base + 1);
    repeat (8) @(negedge clk);
    ctl_mute = 1'b0;
    checks++;
    if (trig_count !== base + 1) begin errors++; $display("FAIL timeout_count: got %0d, required 1", trig_count - base); end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== exp_status(1'b0)) begin errors++; $display("FAIL timeout_status: got %h, required %h", d, exp_status(1'b0)); end
    bus_write(A_CTRL, 32'h11);
    ctrl_m   = 2'b01;
    tx_ovf_m = 1'b0;
    bus_read(A_STATUS, d);
    checks++;
    if (d !== exp_status(1'b0)) begin errors++; $display("FAIL timeout_clear: got %h, required %h", d, exp_status(1'b0)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    logic [7:0]  b [5];
    logic [7:0]  exp_rx [5];
    int base;
    for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      bus_read(A_DATA, d);
      e = model_read();
      checks++;
      if (d !== e) begin errors++; $display("FAIL empty_read%0d: got %h, required %h", i, d, e); end
    end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== exp_status(1'b0)) begin errors++; $display("FAIL empty_status: got %h, required %h", d, exp_status(1'b0)); end
    bus_write(A_CTRL, 32'h0);
    ctrl_m = 2'b00;
    bus_read(A_STATUS, d);
    bus_if.bus_addr  = A_DATA;
    bus_if.bus_wdata = {24'h0, b[0]};
    bus_if.bus_we    = 1'b1;
    bus_if.bus_re    = 1'b1;
    @(negedge clk);
    bus_if.bus_we    = 1'b0;
    bus_if.bus_re    = 1'b0;
    model_write(b[0]);
    checks++;
    if (bus_if.bus_rdata !== 32'h0) begin errors++; $display("FAIL we_re_rdata: got %h, required 0", bus_if.bus_rdata); end
    for (int i = 1; i < 4; i++) begin
      bus_write(A_DATA, {24'h0, b[i]});
      model_write(b[i]);
    end
    base = trig_count;
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DATA, {24'h0, b[4]});
    ctrl_m = 2'b01;
    void'(tx_m.pop_front());
    tx_m.push_back(b[4]);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== exp_status(1'b1)) begin errors++; $display("FAIL full_push_pop_status: got %h, required %h", d, exp_status(1'b1)); end
    tx_m.delete();
    for (int i = 0; i < 5; i++) exp_rx[i] = b[i] ^ resp_key;
    for (int i = 0; i < 5; i++) begin
      wait_triggers(base + i + 1);
      repeat (11) @(negedge clk);
      bus_read(A_DATA, d);
      checks++;
      if (d !== {24'h0, exp_rx[i]}) begin errors++; $display("FAIL b2b_rx%0d: got %h, required %h", i, d, {24'h0, exp_rx[i]}); end
    end
    checks++;
    if (trig_count !== base + 5) begin errors++; $display("FAIL b2b_count: got %0d, required 5", trig_count - base); end
  endtask

  task automatic test_reset_midxfer();
    logic [31:0] d, e;
    logic [7:0]  b2;
    int base, busy_base;
    bus_write(A_CTRL, 32'h0);
    ctrl_m = 2'b00;
    bus_write(A_DATA, {24'h0, 8'($urandom)});
    bus_write(A_DATA, {24'h0, 8'($urandom)});
    base = trig_count;
    busy_base = trig_busy_count;
    bus_write(A_CTRL, 32'h1);
    wait_triggers(base + 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_if.spi_trigger, bus_if.spi_command, bus_if.irq} !== 10'h0)
      begin errors++; $display("FAIL midrst_outputs: trig=%b cmd=%h irq=%b, required all 0",
        bus_if.spi_trigger, bus_if.spi_command, bus_if.irq); end
    rst = 1'b0;
    model_reset();
    bus_read(A_STATUS, d);
    checks++;
    if (d !== exp_status(1'b0)) begin errors++; $display("FAIL midrst_status: got %h, required %h", d, exp_status(1'b0)); end
    b2 = 8'($urandom);
    bus_write(A_DATA, {24'h0, b2});
    model_write(b2);
    bus_write(A_CTRL, 32'h1);
    ctrl_m = 2'b01;
    model_drain();
    wait_triggers(base + 2);
    repeat (14) @(negedge clk);
    checks++;
    if (trig_count !== base + 2) begin errors++; $display("FAIL midrst_count: got %0d, required 2", trig_count - base); end
    checks++;
    if (trig_busy_count !== busy_base) begin errors++; $display("FAIL midrst_launch_busy: %0d launches while busy, required 0", trig_busy_count - busy_base); end
    for (int i = 0; i < 2; i++) begin
      bus_read(A_DATA, d);
      e = model_read();
      checks++;
      if (d !== e) begin errors++; $display("FAIL midrst_rx%0d: got %h, required %h", i, d, e); end
    end
  endtask

  initial begin
    bus_if.bus_addr  = 4'h0;
    bus_if.bus_wdata = 32'h0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_re    = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_ordered();
    test_tx_overflow();
    test_rx_overflow();
    test_arm_timeout();
    test_back_to_back();
    test_reset_midxfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
